// File: rtl/coreboard1588_pkg.sv
// coreboard1588_pkg: shared timestamp entry type, flag positions and compensation helper.
package coreboard1588_pkg;
  typedef struct packed {
    logic [1:0]  flags;
    logic [31:0] second;
    logic [31:0] nanosecond;
  } ts_entry_t;
  localparam int TS_FLAG_TS = 0;
  localparam int TS_FLAG_PPS = 1;
  localparam logic [31:0] NS_PER_SECOND = 32'd1_000_000_000;
  // Subtract a fixed latency, borrowing one second when nanoseconds underflow.
  function automatic ts_entry_t compensate(input ts_entry_t e, input logic [31:0] comp);
    compensate = e;
    compensate.nanosecond = (e.nanosecond >= comp) ? e.nanosecond - comp : e.nanosecond + NS_PER_SECOND - comp;
    compensate.second = (e.nanosecond >= comp) ? e.second : e.second - 32'd1;
  endfunction
endpackage

// File: rtl/coreboard1588_sync_fifo.sv
// coreboard1588_sync_fifo: single-clock first-word-fall-through FIFO with output register.
module coreboard1588_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] mem_count;
  logic out_valid, pop, push, load;
  assign pop = rd_en & out_valid;
  assign level = mem_count + LW'(out_valid);
  assign full = level == LW'(DEPTH);
  assign empty = ~out_valid;
  // Fullness is judged after a same-cycle pop, so a full FIFO being drained still accepts.
  assign push = wr_en & ~clear & (~full | pop);
  assign load = (mem_count != '0) & (~out_valid | pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      rd_data <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_count <= mem_count + LW'(push) - LW'(load);
      out_valid <= load | (out_valid & ~pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/coreboard1588_ts_capture.sv
// coreboard1588_ts_capture: latches RTC time on TS/PPS events, removes sync latency, queues captures.
module coreboard1588_ts_capture import coreboard1588_pkg::*; #(
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_NS_COMP = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ts_event,
  input  logic                          pps_event,
  input  logic [31:0]                   rtc_second,
  input  logic [31:0]                   rtc_nanosecond,
  input  logic                          ctrl_enable,
  input  logic                          ctrl_pps_capture,
  input  logic                          ctrl_clear,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [31:0]                   m_second,
  output logic [31:0]                   m_nanosecond,
  output logic [1:0]                    m_flags,
  output logic [$clog2(C_FIFO_DEPTH):0] stat_level,
  output logic                          stat_overflow,
  output logic [15:0]                   stat_drop_count
);
  logic [1:0] flags;
  logic trig, s1_valid, s2_valid, full, empty, wr_en, drop;
  ts_entry_t s1, s2, head;
  always_comb begin
    flags = '0;
    flags[TS_FLAG_TS] = ts_event;
    flags[TS_FLAG_PPS] = ctrl_pps_capture & pps_event;
  end
  assign trig = ctrl_enable & (|flags);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1_valid <= trig & ~ctrl_clear;
      s2_valid <= s1_valid & ~ctrl_clear;
      if (trig) s1 <= '{flags: flags, second: rtc_second, nanosecond: rtc_nanosecond};
      if (s1_valid) s2 <= compensate(s1, 32'(C_NS_COMP));
    end
  end
  assign wr_en = s2_valid & ~ctrl_clear;
  assign drop = wr_en & full & ~(m_valid & m_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_overflow <= 1'b0;
      stat_drop_count <= '0;
    end else if (ctrl_clear) begin
      stat_overflow <= 1'b0;
      stat_drop_count <= '0;
    end else if (drop) begin
      stat_overflow <= 1'b1;
      stat_drop_count <= stat_drop_count + 16'(stat_drop_count != 16'hFFFF);
    end
  end
  coreboard1588_sync_fifo #(.WIDTH($bits(ts_entry_t)), .DEPTH(C_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(ctrl_clear),
    .wr_en(wr_en),
    .wr_data(s2),
    .rd_en(m_ready),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(stat_level)
  );
  assign m_valid = ~empty;
  assign m_second = head.second;
  assign m_nanosecond = head.nanosecond;
  assign m_flags = head.flags;
endmodule

// File: tb/tb_coreboard1588_ts_capture.sv
// tb_coreboard1588_ts_capture: scoreboard bench with a time-arithmetic reference model.
module tb_coreboard1588_ts_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ts_event = 0, pps_event = 0, ctrl_enable = 0, ctrl_pps_capture = 0, ctrl_clear = 0, m_ready = 0;
  logic [31:0] rtc_second = 0, rtc_nanosecond = 0;
  logic m_valid, stat_overflow;
  logic [31:0] m_second, m_nanosecond;
  logic [1:0] m_flags;
  logic [4:0] stat_level;
  logic [15:0] stat_drop_count;
  logic [65:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  coreboard1588_ts_capture dut (
    .clk(clk), .rst(rst), .ts_event(ts_event), .pps_event(pps_event),
    .rtc_second(rtc_second), .rtc_nanosecond(rtc_nanosecond),
    .ctrl_enable(ctrl_enable), .ctrl_pps_capture(ctrl_pps_capture), .ctrl_clear(ctrl_clear),
    .m_valid(m_valid), .m_ready(m_ready), .m_second(m_second), .m_nanosecond(m_nanosecond),
    .m_flags(m_flags), .stat_level(stat_level), .stat_overflow(stat_overflow),
    .stat_drop_count(stat_drop_count)
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: treat time as one count of nanoseconds, subtract 24, wrap over the 2^32-second range.
  function automatic logic [65:0] model(input logic ts, input logic pps, input logic pcap,
                                        input logic [31:0] sec, input logic [31:0] ns);
    longint total;
    total = longint'(sec) * 1000000000 + longint'(ns) - 24;
    if (total < 0) total = total + 64'sd4294967296000000000;
    return {pcap & pps, ts, 32'(total / 1000000000), 32'(total % 1000000000)};
  endfunction

  function automatic logic [31:0] rnd_ns();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 30)) : 32'($urandom_range(0, 999_999_999));
  endfunction

  task automatic step(input logic ts, input logic pps, input logic [31:0] sec, input logic [31:0] ns, input bit keep);
    ts_event = ts;
    pps_event = pps;
    rtc_second = sec;
    rtc_nanosecond = ns;
    if (keep && !ctrl_clear && ctrl_enable && (ts || (ctrl_pps_capture && pps)))
      sb.push_back(model(ts, pps, ctrl_pps_capture, sec, ns));
    @(posedge clk);
    #1;
    ts_event = 0;
    pps_event = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, $urandom, rnd_ns(), 1);
  endtask

  task automatic wait_drain();
    m_ready = 1;
    for (int i = 0; i < 300 && (sb.size() != 0 || m_valid); i++) idle(1);
    chk("drain_left", 66'(sb.size()), 66'd0);
    chk("drain_valid", 66'(m_valid), 66'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && !ctrl_clear && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_entry: got %0h expected none", {m_flags, m_second, m_nanosecond});
      end else chk("entry", {m_flags, m_second, m_nanosecond}, sb.pop_front());
    end
  end

  initial begin
    #1;
    chk("reset_outputs", {m_valid, m_second, m_nanosecond, m_flags}, 66'd0);
    chk("reset_stats", {stat_level, stat_overflow, stat_drop_count}, 66'd0);
    @(posedge clk);
    #1;
    rst = 0;
    ctrl_enable = 1;
    ctrl_pps_capture = 1;
    m_ready = 1;
    // latency: event at edge N, visible after N+3
    step(1, 0, 32'd5, 32'd500_000_000, 1);
    idle(2);
    chk("latency_not_yet", 66'(m_valid), 66'd0);
    chk("level_after_write", 66'(stat_level), 66'd1);
    idle(1);
    chk("latency_valid", 66'(m_valid), 66'd1);
    wait_drain();
    step(0, 1, 32'd7, 32'd10, 1);
    step(0, 1, 32'd0, 32'd0, 1);
    step(1, 1, 32'd100, 32'd24, 1);
    ctrl_pps_capture = 0;
    step(1, 1, 32'd101, 32'd23, 1);
    step(0, 1, 32'd102, 32'd50, 1);
    ctrl_pps_capture = 1;
    ctrl_enable = 0;
    step(1, 1, 32'd103, 32'd60, 1);
    ctrl_enable = 1;
    wait_drain();
    // overflow: 20 pulses with no consumer
    m_ready = 0;
    for (int i = 0; i < 20; i++) step(1, 0, 32'(i + 1), 32'(1000 + i), i < 16);
    idle(3);
    chk("ovf_level", 66'(stat_level), 66'd16);
    chk("ovf_sticky", 66'(stat_overflow), 66'd1);
    chk("ovf_drops", 66'(stat_drop_count), 66'd4);
    step(1, 0, 32'd17, 32'd2000, 1);
    idle(1);
    m_ready = 1;
    idle(1);
    chk("full_pop_write_level", 66'(stat_level), 66'd16);
    chk("full_pop_write_drops", 66'(stat_drop_count), 66'd4);
    wait_drain();
    chk("ovf_persists", 66'(stat_overflow), 66'd1);
    // clear with 5 queued and a write landing in the clear cycle
    m_ready = 0;
    for (int i = 0; i < 6; i++) step(1, 0, $urandom, rnd_ns(), 0);
    idle(1);
    chk("pre_clear_level", 66'(stat_level), 66'd5);
    ctrl_clear = 1;
    idle(1);
    ctrl_clear = 0;
    chk("clear_level", 66'(stat_level), 66'd0);
    chk("clear_valid", 66'(m_valid), 66'd0);
    chk("clear_stats", {stat_overflow, stat_drop_count}, 66'd0);
    idle(3);
    chk("clear_settled", {m_valid, stat_level, stat_overflow, stat_drop_count}, 66'd0);
    // randomized traffic, kept below capacity so nothing drops
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      ctrl_enable = ($urandom_range(0, 9) != 0);
      ctrl_pps_capture = $urandom_range(0, 1);
      if (sb.size() < 12) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom, rnd_ns(), 1);
      else idle(1);
    end
    ctrl_enable = 1;
    wait_drain();
    chk("random_no_drop", {stat_overflow, stat_drop_count}, 66'd0);
    // async reset mid-drain
    m_ready = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 32'hA000 + 32'(i), 32'd777_000_000, 1);
    idle(4);
    m_ready = 1;
    idle(1);
    #2 rst = 1;
    #1;
    sb.delete();
    chk("async_rst_outputs", {m_valid, m_second, m_nanosecond, m_flags}, 66'd0);
    chk("async_rst_stats", {stat_level, stat_overflow, stat_drop_count}, 66'd0);
    m_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
    step(1, 0, 32'd9, 32'd3, 1);
    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coreboard1588_ts_capture.md
# coreboard1588_ts_capture

Timestamp capture queue sitting directly downstream of the RTC block. Latches the RTC time (second/nanosecond) on every synchronized TS or PPS event pulse, removes the fixed input synchronizer latency, and buffers the results in a FIFO. Software or the AXI register block drains the FIFO through a valid/ready stream. Overflow and dropped-event statistics are kept for the status registers.

## Interface
Parameters:
- C_FIFO_DEPTH, 16, entries; power of two, 4..256
- C_NS_COMP, 24, nanoseconds subtracted from each capture (3 cycles × 8 ns at 125 MHz)

Ports:
- clk  in  1  system clock, same domain as RTC
- rst  in  1  asynchronous, active-high reset
- ts_event  in  1  single-cycle pulse, already synchronized (RTC ts_out)
- pps_event  in  1  single-cycle pulse, already synchronized (RTC pps_out)
- rtc_second  in  32  live RTC second
- rtc_nanosecond  in  32  live RTC nanosecond
- ctrl_enable  in  1  1 = capture events; 0 = ignore events, FIFO still drains
- ctrl_pps_capture  in  1  1 = also capture on pps_event
- ctrl_clear  in  1  single-cycle; flush FIFO, clear statistics
- m_valid  out  1  entry available
- m_ready  in  1  consumer accepts entry
- m_second  out  32  captured second
- m_nanosecond  out  32  captured nanosecond
- m_flags  out  2  bit0 = TS source, bit1 = PPS source
- stat_level  out  $clog2(C_FIFO_DEPTH)+1  entries stored, including the one on m_*
- stat_overflow  out  1  sticky; set when an entry is dropped
- stat_drop_count  out  16  dropped entries, saturating at 0xFFFF

## Operation
- Trigger: trig = ctrl_enable & (ts_event | (ctrl_pps_capture & pps_event)). Flags = {ctrl_pps_capture & pps_event, ts_event}. Simultaneous TS and PPS pulses produce one entry with flags = 2'b11.
- Stage 1 (capture): on trig, register rtc_second, rtc_nanosecond, flags, and a valid bit.
- Stage 2 (compensate): if ns ≥ C_NS_COMP, ns −= C_NS_COMP. Otherwise ns = ns + 10^9 − C_NS_COMP and second −= 1, wrapping 0 to 0xFFFFFFFF. Use 32-bit unsigned arithmetic; the borrow is applied in both RTC modes.
- Stage 3 (write): push {flags, second, ns}, 66 bits, into the FIFO.
- Full rule: fullness is evaluated after the same-cycle pop. A write while full with m_ready=0 is dropped: stat_overflow is set and stat_drop_count increments, saturating.
- Output: first-word-fall-through. m_* hold steady while m_valid & !m_ready. A pop occurs on m_valid & m_ready.
- ctrl_clear: synchronous. Empties the FIFO and the stage 1/2 valid bits, clears stat_overflow and stat_drop_count. It wins over a same-cycle write or pop; that write is discarded and not counted as a drop.
- Deasserting ctrl_enable does not cancel entries already in stages 1/2.

## Timing
- Reset values: m_valid=0, m_second=0, m_nanosecond=0, m_flags=0, stat_level=0, stat_overflow=0, stat_drop_count=0. All pipeline valid bits are 0.
- Latency: an event sampled at edge N is written at edge N+2. If the FIFO was empty, m_valid is high after edge N+3.
- Throughput: one event per cycle is sustained with no bubbles. Back-to-back pulses give consecutive entries.
- stat_level updates in the cycle after the push or pop. A simultaneous push and pop leaves it unchanged.
- Reset asserted mid-operation: everything returns to reset values immediately, asynchronously. The first capture is possible on the first edge after rst deasserts.

## Structure
- coreboard1588_pkg holds:
  - ts_entry_t packed struct {flags[1:0], second[31:0], nanosecond[31:0]}
  - flag constants TS_FLAG_TS=0, TS_FLAG_PPS=1
  - NS_PER_SECOND = 10^9
- Sub-module coreboard1588_sync_fifo: parameterized width/depth, single-clock, FWFT, async active-high reset, with full/empty/level outputs.
- The top level contains the trigger logic, the capture/compensate pipeline, the drop statistics and the clear logic.

## Test plan
- Basic capture: rtc = (5 s, 500_000_000 ns), one ts_event pulse → after 3 edges m_valid=1 with (5, 499_999_976), flags=01.
- Borrow: rtc = (7, 10) on a pps_event with ctrl_pps_capture=1 → entry (6, 999_999_986), flags=10. With rtc = (0, 0) → (0xFFFFFFFF, 999_999_976).
- Simultaneous events: ts and pps in the same cycle → exactly one entry, flags=11. With ctrl_pps_capture=0 → flags=01. With ctrl_enable=0 → no entry.
- Overflow: DEPTH=16, m_ready=0, 20 pulses → stat_level=16, stat_overflow=1, stat_drop_count=4. Entries 1..16 drain in order. A 17th pulse arriving with m_ready=1 on a full FIFO is accepted.
- Clear and reset: ctrl_clear asserted in the same cycle as a write and with 5 entries queued → stat_level=0, m_valid=0, statistics 0, no drop counted. Async rst pulse mid-drain → all outputs 0 without a clock edge.
